seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display sharing a single 4-bit-to-7-segment decoder. It holds a NUM_DIGITS-wide BCD/hex display word and steps through the digits one at a time. For each digit it:
- presents that digit's code to the shared decoder,
- registers the returned segment pattern,
- drives a one-hot digit enable.

New display words arrive through a valid/ready handshake and take effect only at frame boundaries, so a display never shows a mix of old and new digits. The block sits between the value producer (counter/ALU status logic) and the display pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 12 +
 rtl/seven_seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake carrying a full display word from the value producer
// into the scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display
// sharing one external 4-bit-to-7-segment decoder.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    lz_suppress,
    seven_seg_scan_ctrl_if.slave    load,
    output logic [3:0]              dec_code,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SHOW_END = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] disp, shadow;
    logic                    pending;
    logic                    boundary;
    logic                    suppressed;
    logic                    lit;
    logic                    accept;

    assign load.load_ready = !pending;
    assign accept          = load.load_valid && !pending;
    assign dec_code        = disp[4*idx +: 4];
    assign frame_done      = boundary;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = SHOW;
                end
                SHOW: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == SHOW_END) state_nxt = BLANK;
                end
                BLANK: begin
                    if (cnt == SLOT_END) begin
                        cnt_nxt   = '0;
                        state_nxt = SHOW;
                        if (idx == IDX_LAST) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A digit is blanked when it and every more-significant digit are zero.
    always_comb begin
        suppressed = 1'b0;
        if (lz_suppress && idx != '0) begin
            suppressed = 1'b1;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (i >= 32'(idx) && disp[4*i +: 4] != 4'h0) suppressed = 1'b0;
            end
        end
    end

    // Gating with enable darkens the display on the same edge that drops to IDLE.
    assign lit = (state == SHOW) && enable && !suppressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            seg_out <= '0;
            an      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                shadow  <= load.load_data;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            seg_out <= lit ? dec_seg : '0;
            an      <= lit ? (NUM_DIGITS'(1) << idx) : '0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: expected per-cycle outputs are
// queued from the stimulus and popped as the DUT advances.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          lz_suppress = 1'b0;
    logic [3:0]    dec_code;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_out;
    logic [ND-1:0] an;
    logic          frame_done;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .lz_suppress(lz_suppress),
        .load(lif),
        .dec_code(dec_code),
        .dec_seg(dec_seg),
        .seg_out(seg_out),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'h0: seg7 = 7'b1111110;
            4'h1: seg7 = 7'b0110000;
            4'h2: seg7 = 7'b1101101;
            4'h3: seg7 = 7'b1111001;
            4'h4: seg7 = 7'b0110011;
            4'h5: seg7 = 7'b1011011;
            4'h6: seg7 = 7'b1011111;
            4'h7: seg7 = 7'b1110000;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb dec_seg = seg7(dec_code);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected outputs for the first n cycles of a frame showing 'word'.
    task automatic push_frame(input logic [15:0] word, input logic lz, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int d;
            int pos;
            logic supp;
            logic [15:0] upper;
            logic [3:0] nib;
            d     = i / RD;
            pos   = i % RD;
            upper = word >> (4 * d);
            nib   = upper[3:0];
            supp  = lz && (d != 0) && (upper == 16'h0);
            e     = '0;
            if (pos < RD - BC && !supp) begin
                e.an  = ND'(1) << d;
                e.seg = seg7(nib);
            end
            e.fd = (i == ND * RD - BC);
            q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                e = q.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("seg_out", 32'(seg_out), 32'(e.seg));
                check("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 0);
        check("rst_seg", 32'(seg_out), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_ready", 32'(lif.load_ready), 1);
        check("rst_code", 32'(dec_code), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load 0x1234 while idle; it appears after the first frame boundary.
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h1234;
        push_idle(1);
        run(1);
        lif.load_valid = 1'b0;
        check("ready_after_accept", 32'(lif.load_ready), 0);
        enable = 1'b1;
        push_idle(1);
        push_frame(16'h0000, 1'b0, 32);
        run(33);
        check("ready_after_apply", 32'(lif.load_ready), 1);
        push_frame(16'h1234, 1'b0, 32);
        run(32);

        // Leading-zero suppression on and off.
        lz_suppress    = 1'b1;
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h0007;
        push_frame(16'h1234, 1'b1, 32);
        run(1);
        lif.load_valid = 1'b0;
        run(31);
        push_frame(16'h0007, 1'b1, 32);
        run(32);
        lz_suppress = 1'b0;
        push_frame(16'h0007, 1'b0, 32);
        run(32);

        // Back-to-back loads: the second waits for the boundary.
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h1111;
        push_frame(16'h0007, 1'b0, 32);
        run(1);
        check("b2b_ready_low", 32'(lif.load_ready), 0);
        lif.load_data = 16'h2222;
        run(30);
        check("b2b_ready_held", 32'(lif.load_ready), 0);
        run(1);
        check("b2b_ready_rise", 32'(lif.load_ready), 1);
        push_frame(16'h1111, 1'b0, 32);
        run(1);
        lif.load_valid = 1'b0;
        check("b2b_second_accept", 32'(lif.load_ready), 0);
        run(31);
        push_frame(16'h2222, 1'b0, 32);
        run(32);

        // Load accepted in the boundary cycle is applied one frame later.
        push_frame(16'h2222, 1'b0, 32);
        run(31);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h5678;
        run(1);
        lif.load_valid = 1'b0;
        check("bnd_ready_low", 32'(lif.load_ready), 0);
        push_frame(16'h2222, 1'b0, 32);
        run(32);
        push_frame(16'h5678, 1'b0, 32);
        run(32);

        // Drop enable during digit 2, then restart from digit 0.
        push_frame(16'h5678, 1'b0, 19);
        run(19);
        enable = 1'b0;
        push_idle(4);
        run(4);
        enable = 1'b1;
        push_idle(1);
        push_frame(16'h5678, 1'b0, 32);
        run(33);

        // Reset during BLANK with a word pending discards it.
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h9999;
        push_frame(16'h5678, 1'b0, 7);
        run(1);
        lif.load_valid = 1'b0;
        run(6);
        check("pre_rst_pending", 32'(lif.load_ready), 0);
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check("mid_rst_an", 32'(an), 0);
        check("mid_rst_seg", 32'(seg_out), 0);
        check("mid_rst_fd", 32'(frame_done), 0);
        check("mid_rst_ready", 32'(lif.load_ready), 1);
        check("mid_rst_code", 32'(dec_code), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        push_idle(1);
        push_frame(16'h0000, 1'b0, 32);
        push_frame(16'h0000, 1'b0, 32);
        run(65);

        check("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
